btn_scan_ctrl: RTL
==================

Name: btn_scan_ctrl

Overview:
Debounce scheduler for a bank of raw push-buttons. One shared prescaler and a scan FSM visit each button once per sample tick, replacing per-button wide counters.
Produces debounced levels and one-cycle press pulses. Queues press events in a small FIFO with a valid/ready handshake for the downstream controller FSM.
Sits between board buttons and the top-level control logic.

Parameters:
NUM_BTN, 4, number of buttons (2..16)
TICK_DIV, 50000, clk cycles per sample tick (1 ms @ 50 MHz); must exceed NUM_BTN+2
STABLE_TICKS, 20, consecutive disagreeing ticks before a level change is accepted (>=2)
FIFO_DEPTH, 4, press-event queue depth (power of 2, >=2)
REPEAT_TICKS, 500, hold time in ticks before auto-repeat; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_raw  in  NUM_BTN  raw button inputs, asynchronous, 1 = pressed
btn_level  out  NUM_BTN  debounced level
btn_pulse  out  NUM_BTN  one-cycle pulse on accepted 0->1 transition
evt_valid  out  1  event FIFO non-empty
evt_id  out  $clog2(NUM_BTN)  button index at FIFO head
evt_ready  in  1  consumer pops head when evt_valid && evt_ready
overflow  out  1  sticky: a press was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset, asynchronous and active-high. Clears all outputs, sync flops, prescaler, counters and FIFO pointers. FSM goes to IDLE. Reset mid-scan abandons the scan; no partial event is queued.
- Input sync: 2-flop synchronizer per bit. s[i] is the second stage.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = 1 for one cycle when the count equals TICK_DIV-1.
- FSM has two states:
  - IDLE: on tick, set idx = 0 and go to SCAN.
  - SCAN: process button idx this cycle. If idx == NUM_BTN-1, return to IDLE; otherwise idx += 1. A scan therefore takes NUM_BTN cycles. A tick arriving during SCAN is impossible by the TICK_DIV constraint.
- Per-button processing at idx = i:
  - if s[i] == btn_level[i]: cnt[i] <= 0
  - else if cnt[i] == STABLE_TICKS-1: btn_level[i] <= s[i] and cnt[i] <= 0. If s[i] == 1, assert btn_pulse[i] in the next cycle and push i.
  - else: cnt[i] += 1
  - cnt width is $clog2(STABLE_TICKS); saturation is never reached.
- Acceptance latency: a clean edge is accepted on the STABLE_TICKS-th tick after it passes the synchronizer. It is accepted in the cycle of that button's scan slot.
- Glitches: a bounce back to the level resets cnt, so the change is rejected.
- Release (1->0): updates btn_level only. No pulse, no event.
- FIFO:
  - registered pointers plus count. evt_valid = (count != 0). evt_id is the head entry, combinationally from storage.
  - push while full: drop the event and set overflow.
  - push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - pop while empty: ignored.
  - pushes occur at most once per cycle (one button per cycle).
- overflow: set has priority over ovf_clr when both occur in the same cycle.
- Event order matches scan order: lower index first within one tick.

Optional Feature:
Macro BTN_SCAN_AUTOREPEAT_EN.
- Defined:
  - Each button has a hold counter that runs while btn_level[i] = 1, incrementing in its scan slot.
  - Upon reaching REPEAT_TICKS-1 it reloads to 0 and re-pushes i plus a btn_pulse[i], subject to the same FIFO/overflow rules.
  - The hold counter clears when the level goes to 0.
- Undefined: no hold counters are synthesized, REPEAT_TICKS is unused, and exactly one event is produced per press.

Decomposition:
Package btn_scan_pkg:
- FSM state enum (ST_IDLE, ST_SCAN)
- localparam helper functions for idx, cnt and FIFO pointer widths
Sub-module btn_evt_fifo:
- parameterized DEPTH/WIDTH synchronous FIFO with full/empty and push_drop output
- rst is asynchronous, active-high

Test Plan:
Bench params: NUM_BTN=4, TICK_DIV=8, STABLE_TICKS=3, FIFO_DEPTH=2.
1. Clean press btn_raw=0001 held → btn_level[0]=1 and a single btn_pulse[0] at the 3rd tick's slot 0. evt_valid=1, evt_id=0. Pop with evt_ready → evt_valid=0.
2. Bounce: btn_raw[1] high for 2 ticks, low 1 tick, high 3 ticks → exactly one event with id 1, accepted after the final 3 stable ticks. btn_level[1] never toggles early.
3. Simultaneous press btn_raw=1111, evt_ready=0 → events 0,1 queued, 2 and 3 dropped, overflow=1. ovf_clr → overflow=0. Pops return 0 then 1.
4. Full FIFO with evt_ready=1 held during a new press → push+pop same cycle, no overflow, count stays 2.
5. Assert rst during SCAN with a pending cnt → all outputs 0 immediately. After release, a press needs the full 3 ticks again.
6. With BTN_SCAN_AUTOREPEAT_EN and REPEAT_TICKS=4, hold btn 2 for 12 ticks after acceptance → 1 initial event plus 3 repeat events, all with id 2.

Source files
------------

// File: rtl/btn_scan_pkg.sv
// Shared types and width helpers for the button scan debouncer.
package btn_scan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    if (n > 1) return $clog2(n);
    return 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_btn);
    return width_of(num_btn);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned stable_ticks);
    return width_of(stable_ticks);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return width_of(depth);
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Small synchronous FIFO for press events; flags pushes dropped while full.
module btn_evt_fifo
  import btn_scan_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             push_drop,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so push+pop while full both succeed.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_drop = push && !do_push;
  assign head      = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Time-multiplexed button debouncer: one prescaler, one scan FSM visiting
// each button per sample tick, and a press-event FIFO.
// Optional auto-repeat on held buttons: define BTN_SCAN_AUTOREPEAT_EN.
module btn_scan_ctrl
  import btn_scan_pkg::*;
#(
  parameter int unsigned NUM_BTN      = 4,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 20,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REPEAT_TICKS = 500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_raw,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic [NUM_BTN-1:0]         btn_pulse,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  input  logic                       evt_ready,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned IW = idx_width(NUM_BTN);
  localparam int unsigned CW = cnt_width(STABLE_TICKS);
  localparam int unsigned DW = $clog2(TICK_DIV);

  // Reject parameter sets the scan schedule cannot honour.
  if (NUM_BTN < 2 || NUM_BTN > 16) begin : g_bad_num_btn
    $error("btn_scan_ctrl: NUM_BTN must be 2..16");
  end
  if (TICK_DIV <= NUM_BTN + 2) begin : g_bad_tick_div
    $error("btn_scan_ctrl: TICK_DIV must exceed NUM_BTN+2");
  end
  if (STABLE_TICKS < 2) begin : g_bad_stable
    $error("btn_scan_ctrl: STABLE_TICKS must be >= 2");
  end
  if (REPEAT_TICKS < 2) begin : g_bad_repeat
    $error("btn_scan_ctrl: REPEAT_TICKS must be >= 2");
  end

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [DW-1:0]      pre_cnt;
  logic               tick;
  scan_state_t        state;
  logic [IW-1:0]      idx;
  logic [CW-1:0]      cnt [NUM_BTN];
  logic               push_q;
  logic [IW-1:0]      push_id;
  logic               fifo_empty;
  logic               fifo_drop;
  logic               cur_s;
  logic               cur_level;
  logic               agree;
  logic               accept;

`ifdef BTN_SCAN_AUTOREPEAT_EN
  localparam int unsigned HW = cnt_width(REPEAT_TICKS);
  logic [HW-1:0] hold [NUM_BTN];
`endif

  assign tick      = (pre_cnt == DW'(TICK_DIV - 1));
  assign cur_s     = sync2[idx];
  assign cur_level = btn_level[idx];
  assign agree     = (cur_s == cur_level);
  assign accept    = !agree && (cnt[idx] == CW'(STABLE_TICKS - 1));
  assign evt_valid = !fifo_empty;

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Shared prescaler generating one sample tick every TICK_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + 1'b1;
  end

  // Scan FSM: one button per cycle, debounce counters, pulse and push request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      btn_level <= '0;
      btn_pulse <= '0;
      push_q    <= 1'b0;
      push_id   <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
`ifdef BTN_SCAN_AUTOREPEAT_EN
      for (int unsigned i = 0; i < NUM_BTN; i++) hold[i] <= '0;
`endif
    end else begin
      btn_pulse <= '0;
      push_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            idx   <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (agree) begin
            cnt[idx] <= '0;
          end else if (accept) begin
            cnt[idx]       <= '0;
            btn_level[idx] <= cur_s;
            if (cur_s) begin
              btn_pulse[idx] <= 1'b1;
              push_q         <= 1'b1;
              push_id        <= idx;
            end
          end else begin
            cnt[idx] <= cnt[idx] + 1'b1;
          end
`ifdef BTN_SCAN_AUTOREPEAT_EN
          // Hold timer runs while pressed; a release in this slot clears it.
          if (cur_level) begin
            if (accept) begin
              hold[idx] <= '0;
            end else if (hold[idx] == HW'(REPEAT_TICKS - 1)) begin
              hold[idx]      <= '0;
              btn_pulse[idx] <= 1'b1;
              push_q         <= 1'b1;
              push_id        <= idx;
            end else begin
              hold[idx] <= hold[idx] + 1'b1;
            end
          end
`endif
          if (idx == IW'(NUM_BTN - 1)) state <= ST_IDLE;
          else idx <= idx + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  btn_evt_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(IW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_q),
    .push_data(push_id),
    .pop      (evt_ready),
    .empty    (fifo_empty),
    .push_drop(fifo_drop),
    .head     (evt_id)
  );

endmodule
